// File: rtl/branch_predictor.sv
// Gshare direction predictor with a direct-mapped branch target buffer.
// Prediction is purely combinational from f_pc and the registered tables;
// training arrives from Execute and is applied at the clock edge.
// Interface contract: there is no valid/ready handshake anywhere. The block
// is always ready, every cycle presents a prediction for f_pc, and an update
// is consumed in exactly the cycle ex_update_en is high (no backpressure).
module branch_predictor #(
   parameter int PHT_IDX_W = 8,
   parameter int GHR_W     = 8,
   parameter int BTB_IDX_W = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          f_pc,
   output logic                 f_pred_taken,
   output logic [31:0]          f_pred_target,
   output logic [PHT_IDX_W-1:0] f_pht_idx,
   output logic                 f_btb_hit,
   output logic [31:0]          f_btb_target,
   input  logic                 ex_update_en,
   input  logic                 ex_is_uncond,
   input  logic                 ex_actual_taken,
   input  logic [31:0]          ex_pc,
   input  logic [31:0]          ex_actual_target,
   input  logic [PHT_IDX_W-1:0] ex_pht_idx,
   input  logic                 ex_mispredict,
   output logic [31:0]          stat_updates,
   output logic [31:0]          stat_mispredicts
);

   localparam int PHT_N = 1 << PHT_IDX_W;
   localparam int BTB_N = 1 << BTB_IDX_W;
   localparam int TAG_W = 30 - BTB_IDX_W;

   // Tables and history
   logic [1:0]       pht       [PHT_N];
   logic             btb_valid [BTB_N];
   logic [TAG_W-1:0] btb_tag   [BTB_N];
   logic [31:0]      btb_tgt   [BTB_N];
   logic             btb_unc   [BTB_N];
   logic [GHR_W-1:0] ghr;

   // Fetch-side lookup fields
   logic [BTB_IDX_W-1:0] f_btb_i;
   logic [TAG_W-1:0]     f_tag;
   logic [PHT_IDX_W-1:0] ghr_ext;
   logic [BTB_IDX_W-1:0] ex_btb_i;
   logic [TAG_W-1:0]     ex_tag;
   logic                 unused_pc_bits;

   assign f_btb_i  = f_pc[BTB_IDX_W+1:2];
   assign f_tag    = f_pc[31:BTB_IDX_W+2];
   assign ex_btb_i = ex_pc[BTB_IDX_W+1:2];
   assign ex_tag   = ex_pc[31:BTB_IDX_W+2];

   // Instructions are word aligned; the low PC bits carry no information.
   assign unused_pc_bits = ^{f_pc[1:0], ex_pc[1:0]};

   // Zero-extend the history to the PHT index width (works when GHR_W == PHT_IDX_W)
   always_comb begin
      ghr_ext              = '0;
      ghr_ext[GHR_W-1:0]   = ghr;
   end

   assign f_pht_idx     = f_pc[PHT_IDX_W+1:2] ^ ghr_ext;
   assign f_btb_hit     = btb_valid[f_btb_i] && (btb_tag[f_btb_i] == f_tag);
   assign f_btb_target  = f_btb_hit ? btb_tgt[f_btb_i] : 32'd0;
   // Without a BTB hit there is no target to jump to, so never predict taken.
   assign f_pred_taken  = f_btb_hit && (btb_unc[f_btb_i] || pht[f_pht_idx][1]);
   assign f_pred_target = f_pred_taken ? f_btb_target : (f_pc + 32'd4);

   // PHT training: saturating 2-bit counters, conditional branches only
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < PHT_N; i++) pht[i] <= 2'b01;
      end else if (ex_update_en && !ex_is_uncond) begin
         if (ex_actual_taken) begin
            if (pht[ex_pht_idx] != 2'b11) pht[ex_pht_idx] <= pht[ex_pht_idx] + 2'd1;
         end else begin
            if (pht[ex_pht_idx] != 2'b00) pht[ex_pht_idx] <= pht[ex_pht_idx] - 2'd1;
         end
      end
   end

   // Global history: non-speculative, shifted only by resolved conditional branches
   always_ff @(posedge clk) begin
      if (!rst) begin
         ghr <= '0;
      end else if (ex_update_en && !ex_is_uncond) begin
         ghr <= {ghr[GHR_W-2:0], ex_actual_taken};
      end
   end

   // BTB allocation on taken resolutions; not-taken leaves the entry alone
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < BTB_N; i++) begin
            btb_valid[i] <= 1'b0;
            btb_tag[i]   <= '0;
            btb_tgt[i]   <= '0;
            btb_unc[i]   <= 1'b0;
         end
      end else if (ex_update_en && ex_actual_taken) begin
         btb_valid[ex_btb_i] <= 1'b1;
         btb_tag[ex_btb_i]   <= ex_tag;
         btb_tgt[ex_btb_i]   <= ex_actual_target;
         btb_unc[ex_btb_i]   <= ex_is_uncond;
      end
   end

   // Saturating statistics counters
   always_ff @(posedge clk) begin
      if (!rst) begin
         stat_updates     <= '0;
         stat_mispredicts <= '0;
      end else if (ex_update_en) begin
         if (stat_updates != 32'hFFFF_FFFF) stat_updates <= stat_updates + 32'd1;
         if (ex_mispredict && (stat_mispredicts != 32'hFFFF_FFFF))
            stat_mispredicts <= stat_mispredicts + 32'd1;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios followed by
// randomized fetch/resolve traffic compared against a behavioural model.
module tb_branch_predictor;

   logic        clk;
   logic        rst;
   logic [31:0] f_pc;
   logic        f_pred_taken;
   logic [31:0] f_pred_target;
   logic [7:0]  f_pht_idx;
   logic        f_btb_hit;
   logic [31:0] f_btb_target;
   logic        ex_update_en;
   logic        ex_is_uncond;
   logic        ex_actual_taken;
   logic [31:0] ex_pc;
   logic [31:0] ex_actual_target;
   logic [7:0]  ex_pht_idx;
   logic        ex_mispredict;
   logic [31:0] stat_updates;
   logic [31:0] stat_mispredicts;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int          pht_m [256];
   int          ghr_m;
   bit          v_m   [16];
   logic [31:0] tag_m [16];
   logic [31:0] tgt_m [16];
   bit          unc_m [16];
   longint      upd_m;
   longint      mis_m;

   // Pending branches between fetch and resolve (PC and the PHT index used)
   logic [31:0] pend_pc_q[$];
   logic [31:0] exp_q[$];

   branch_predictor dut (
      .clk(clk), .rst(rst), .f_pc(f_pc),
      .f_pred_taken(f_pred_taken), .f_pred_target(f_pred_target),
      .f_pht_idx(f_pht_idx), .f_btb_hit(f_btb_hit), .f_btb_target(f_btb_target),
      .ex_update_en(ex_update_en), .ex_is_uncond(ex_is_uncond),
      .ex_actual_taken(ex_actual_taken), .ex_pc(ex_pc),
      .ex_actual_target(ex_actual_target), .ex_pht_idx(ex_pht_idx),
      .ex_mispredict(ex_mispredict),
      .stat_updates(stat_updates), .stat_mispredicts(stat_mispredicts)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 256; i++) pht_m[i] = 1;
      for (int i = 0; i < 16; i++) begin
         v_m[i] = 0; tag_m[i] = 0; tgt_m[i] = 0; unc_m[i] = 0;
      end
      ghr_m = 0; upd_m = 0; mis_m = 0;
   endtask

   function automatic int model_idx(input logic [31:0] pc);
      return ((pc >> 2) % 256) ^ ghr_m;
   endfunction

   // Compare every DUT output against what the model predicts for pc
   task automatic check_pred(input logic [31:0] pc);
      int bi, pidx;
      bit hit, tk;
      logic [31:0] btgt, ntgt;
      bi   = (pc >> 2) % 16;
      pidx = model_idx(pc);
      hit  = v_m[bi] && (tag_m[bi] == (pc >> 6));
      tk   = hit && (unc_m[bi] || pht_m[pidx] >= 2);
      btgt = hit ? tgt_m[bi] : 32'd0;
      ntgt = tk ? btgt : pc + 32'd4;
      check_eq("btb_hit", {31'd0, f_btb_hit}, {31'd0, hit});
      check_eq("btb_target", f_btb_target, btgt);
      check_eq("pht_idx", {24'd0, f_pht_idx}, pidx[31:0]);
      check_eq("pred_taken", {31'd0, f_pred_taken}, {31'd0, tk});
      check_eq("pred_target", f_pred_target, ntgt);
      check_eq("stat_updates", stat_updates, upd_m[31:0]);
      check_eq("stat_mispredicts", stat_mispredicts, mis_m[31:0]);
   endtask

   task automatic model_update(input logic unc, input logic tk, input logic [31:0] epc,
                               input logic [31:0] etgt, input logic [7:0] eidx, input logic mis);
      int bi;
      if (!unc) begin
         if (tk) pht_m[eidx] = (pht_m[eidx] == 3) ? 3 : pht_m[eidx] + 1;
         else    pht_m[eidx] = (pht_m[eidx] == 0) ? 0 : pht_m[eidx] - 1;
         ghr_m = ((ghr_m * 2) + (tk ? 1 : 0)) % 256;
      end
      if (tk) begin
         bi = (epc >> 2) % 16;
         v_m[bi] = 1; tag_m[bi] = epc >> 6; tgt_m[bi] = etgt; unc_m[bi] = unc;
      end
      if (upd_m < 64'hFFFF_FFFF) upd_m++;
      if (mis && mis_m < 64'hFFFF_FFFF) mis_m++;
   endtask

   // One cycle: drive inputs, check predictions mid-cycle, then apply the edge to the model
   task automatic do_cycle(input logic r, input logic [31:0] pc, input logic en, input logic unc,
                           input logic tk, input logic [31:0] epc, input logic [31:0] etgt,
                           input logic [7:0] eidx, input logic mis);
      rst = r; f_pc = pc; ex_update_en = en; ex_is_uncond = unc; ex_actual_taken = tk;
      ex_pc = epc; ex_actual_target = etgt; ex_pht_idx = eidx; ex_mispredict = mis;
      @(negedge clk);
      check_pred(pc);
      @(posedge clk);
      if (!r) model_reset();
      else if (en) model_update(unc, tk, epc, etgt, eidx, mis);
      #1;
   endtask

   // Present a fetch PC with no update and let the comb outputs settle
   task automatic peek(input logic [31:0] pc);
      rst = 1'b1; ex_update_en = 1'b0; f_pc = pc;
      #1;
   endtask

   initial begin
      logic [31:0] pc, epc, tgt;
      logic [7:0]  eidx;
      logic        r, en, unc, tk, mis;

      rst = 1'b0; f_pc = 32'h100; ex_update_en = 1'b0; ex_is_uncond = 1'b0;
      ex_actual_taken = 1'b0; ex_pc = 32'd0; ex_actual_target = 32'd0;
      ex_pht_idx = 8'd0; ex_mispredict = 1'b0;
      @(posedge clk); #1;
      model_reset();

      // Reset state
      peek(32'h100);
      check_eq("rst_hit", {31'd0, f_btb_hit}, 32'd0);
      check_eq("rst_taken", {31'd0, f_pred_taken}, 32'd0);
      check_eq("rst_target", f_pred_target, 32'h104);
      check_eq("rst_idx", {24'd0, f_pht_idx}, 32'h40);
      check_eq("rst_stat_upd", stat_updates, 32'd0);
      check_eq("rst_stat_mis", stat_mispredicts, 32'd0);

      // First taken conditional update trains BTB and shifts GHR to 1
      do_cycle(1, 32'h100, 1, 0, 1, 32'h100, 32'h200, 8'h40, 1);
      peek(32'h100);
      check_eq("t2_hit", {31'd0, f_btb_hit}, 32'd1);
      check_eq("t2_idx", {24'd0, f_pht_idx}, 32'h41);
      check_eq("t2_taken", {31'd0, f_pred_taken}, 32'd0);
      check_eq("t2_target", f_pred_target, 32'h104);
      check_eq("t2_btb_target", f_btb_target, 32'h200);
      check_eq("t2_stat_mis", stat_mispredicts, 32'd1);

      // Counter saturation at both ends on index 0x10
      for (int i = 0; i < 4; i++) do_cycle(1, 32'h100, 1, 0, 1, 32'h100, 32'h200, 8'h10, 0);
      for (int i = 0; i < 4; i++) do_cycle(1, 32'h100, 1, 0, 0, 32'h100, 32'h200, 8'h10, 0);

      // JAL: always taken on hit, history untouched (GHR = 0xF0)
      do_cycle(1, 32'h300, 1, 1, 1, 32'h300, 32'h80, 8'h00, 0);
      peek(32'h300);
      check_eq("jal_taken", {31'd0, f_pred_taken}, 32'd1);
      check_eq("jal_target", f_pred_target, 32'h80);
      check_eq("jal_idx", {24'd0, f_pht_idx}, 32'h30);

      // Alias overwrite while fetching the victim in the same cycle
      do_cycle(1, 32'h100, 1, 0, 1, 32'h140, 32'h500, 8'h22, 0);
      peek(32'h100);
      check_eq("alias_hit", {31'd0, f_btb_hit}, 32'd0);
      check_eq("alias_target", f_pred_target, 32'h104);
      peek(32'h140);
      check_eq("alias_new_tgt", f_btb_target, 32'h500);

      // Reset mid-run discards the concurrent update
      do_cycle(0, 32'h140, 1, 0, 1, 32'h140, 32'h600, 8'h00, 1);
      peek(32'h140);
      check_eq("mid_rst_hit", {31'd0, f_btb_hit}, 32'd0);
      check_eq("mid_rst_idx", {24'd0, f_pht_idx}, 32'h50);
      check_eq("mid_rst_stat", stat_updates, 32'd0);

      // Randomized fetch/resolve traffic over a small aliasing PC pool
      for (int n = 0; n < 3000; n++) begin
         pc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
         r  = ($urandom_range(0, 199) != 0);
         en = 1'b0; unc = 1'b0; tk = 1'b0; epc = 32'd0; tgt = 32'd0; eidx = 8'd0; mis = 1'b0;
         if (pend_pc_q.size() > 0 && $urandom_range(0, 1) == 1) begin
            en   = 1'b1;
            epc  = pend_pc_q.pop_front();
            eidx = exp_q.pop_front();
            unc  = ($urandom_range(0, 3) == 0);
            tk   = unc ? 1'b1 : $urandom_range(0, 1);
            tgt  = $urandom & 32'hFFFF_FFFC;
            mis  = $urandom_range(0, 1);
         end
         if (pend_pc_q.size() < 6) begin
            pend_pc_q.push_back(pc);
            exp_q.push_back(model_idx(pc));
         end
         do_cycle(r, pc, en, unc, tk, epc, tgt, eidx, mis);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
